// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard/stall controller.
// FSM states, control bundle layout and widths.
package core_defs;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic flush_id;
  } hz_ctrl_t;

  localparam int CTRL_W = $bits(hz_ctrl_t);

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Per-register pending scoreboard for in-flight destinations.
// Set has priority over a same-cycle writeback clear.
module hazard_scoreboard #(
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rd_addr,
  output logic [2**AW-1:0] pend,
  output logic            rs_pend,
  output logic            rd_pend
);

  localparam int N = 2**AW;

  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_mask) | set_mask;
  end

  assign rs_pend = pend[rs_addr];
  assign rd_pend = pend[rd_addr];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the ifetch/id/ex/wb core.
// RAW/WAW detection, multi-cycle sequencing, branch squash.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic                  id_rs_read_i,
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic                  id_rd_read_i,
  input  logic                  id_rd_write_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_multi_i,
  input  logic                  ex_branch_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  bubble_ex_o,
  output logic                  flush_id_o,
  output logic                  issue_o,
  output logic                  busy_o
);

  import core_defs::*;

  hz_state_e        state;
  logic [CNT_W-1:0] cnt;
  hz_ctrl_t         ctrl;

  logic [2**REG_ADDR_W-1:0] pend;
  logic rs_pend;
  logic rd_pend;
  logic raw;
  logic waw;
  logic hazard;
  logic in_multi;
  logic run_br;
  logic run_hz;

  hazard_scoreboard #(
    .AW(REG_ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_o && id_rd_write_i),
    .set_addr (id_rd_addr_i),
    .clr_en   (wb_en_i),
    .clr_addr (wb_addr_i),
    .rs_addr  (id_rs_addr_i),
    .rd_addr  (id_rd_addr_i),
    .pend     (pend),
    .rs_pend  (rs_pend),
    .rd_pend  (rd_pend)
  );

  // No writeback bypass: a register retiring this cycle still blocks.
  assign raw = (id_rs_read_i && rs_pend)
            || (id_rd_read_i && rd_pend);
  assign waw = id_rd_write_i && pend[id_rd_addr_i];
  assign hazard = id_valid_i && (raw || waw);

  assign in_multi = (state == MULTI);
  assign run_br   = !in_multi && ex_branch_i;
  assign run_hz   = !in_multi && !ex_branch_i && hazard;

  always_comb begin
    ctrl    = '0;
    issue_o = 1'b0;
    busy_o  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        in_multi: begin
          ctrl.stall_if = 1'b1;
          ctrl.stall_id = 1'b1;
          busy_o        = 1'b1;
        end
        run_br: begin
          ctrl.flush_id  = 1'b1;
          ctrl.bubble_ex = 1'b1;
        end
        run_hz: begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.bubble_ex = 1'b1;
        end
        default: issue_o = id_valid_i;
      endcase
    end
  end

  assign stall_if_o  = ctrl.stall_if;
  assign stall_id_o  = ctrl.stall_id;
  assign bubble_ex_o = ctrl.bubble_ex;
  assign flush_id_o  = ctrl.flush_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (issue_o && id_multi_i) begin
            state <= MULTI;
            cnt   <= CNT_W'(MC_LAT - 1);
          end
        end
        MULTI: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
